fpu: RTL and testbench

- Single-precision (IEEE-754 binary32) floating-point unit with a private 32-entry x 32-bit register file.
- A host issues one command at a time: opcode, two source register indices and one destination index, plus an immediate word.
- The unit executes the command, writes the result back to the register file, and pulses valid.
- It sits beside the integer core as a coprocessor. Register loads and stores go through in_data/out_data; compare results are returned on cond.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_addsub.sv | 140 ++++++++++++++
 rtl/fpu.sv | 211 +++++++++++++++++++++
 tb/tb_fpu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 FPU: opcodes, FSM states, the quiet-NaN
// pattern and the per-opcode execute latency.
package fpu_pkg;

   localparam logic [5:0] OPSET  = 6'd0;
   localparam logic [5:0] OPGET  = 6'd1;
   localparam logic [5:0] OPFMV  = 6'd2;
   localparam logic [5:0] OPFNEG = 6'd3;
   localparam logic [5:0] OPFABS = 6'd4;
   localparam logic [5:0] OPFADD = 6'd8;
   localparam logic [5:0] OPFSUB = 6'd9;
   localparam logic [5:0] OPFMUL = 6'd10;
   localparam logic [5:0] OPFEQ  = 6'd16;
   localparam logic [5:0] OPFLT  = 6'd17;
   localparam logic [5:0] OPFLE  = 6'd18;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_t;

   // Cycles spent in EXEC: arithmetic ops carry one internal pipeline register.
   function automatic logic [1:0] op_latency(input logic [5:0] op);
      return (op == OPFADD || op == OPFSUB || op == OPFMUL) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/fpu_addsub.sv
// Two-stage binary32 adder/subtractor: align and add into a pipeline register,
// then normalize and round-to-nearest-even. Subnormals are flushed to zero.
module fpu_addsub
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        i_en,
   input  logic        i_sub,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_res
);

   logic        w_sb;
   logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic        w_swap;
   logic        w_sbig, w_ssml;
   logic [7:0]  w_ebig, w_esml;
   logic [26:0] w_mbig, w_msml;
   logic        w_spec_p0;
   logic [31:0] w_spv_p0;
   logic [27:0] w_sum_p0;

   logic        r_spec_p1;
   logic [31:0] r_spv_p1;
   logic        r_sign_p1;
   logic [7:0]  r_exp_p1;
   logic [27:0] r_sum_p1;

   logic [4:0]        w_lz;
   logic [26:0]       w_norm;
   logic signed [9:0] w_nexp;

   function automatic logic [26:0] shr_sticky(input logic [26:0] v, input logic [7:0] d);
      logic [26:0] mask;
      logic [26:0] r;
      mask = '0;
      r    = '0;
      if (d >= 8'd27) begin
         r = {26'd0, |v};
      end else begin
         mask = (27'd1 << d) - 27'd1;
         r    = v >> d;
         r[0] = r[0] | (|(v & mask));
      end
      return r;
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       hit;
      n   = '0;
      hit = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!hit) begin
            if (v[i]) hit = 1'b1;
            else      n   = n + 5'd1;
         end
      end
      return n;
   endfunction

   // m[26] is the hidden bit, m[2] guard, m[1:0] round/sticky.
   function automatic logic [31:0] rnd_pack(input logic s, input logic signed [9:0] e,
                                            input logic [26:0] m);
      logic              up;
      logic [24:0]       mr;
      logic signed [9:0] e2;
      logic [31:0]       r;
      up = m[2] & (m[1] | m[0] | m[3]);
      mr = {1'b0, m[26:3]} + {24'd0, up};
      e2 = e;
      if (mr[24]) e2 = e + 10'sd1;
      if (e2 >= 10'sd255)     r = {s, 8'hFF, 23'd0};
      else if (e2 <= 10'sd0)  r = {s, 31'd0};
      else                    r = {s, e2[7:0], (mr[24] ? mr[23:1] : mr[22:0])};
      return r;
   endfunction

   // Stage 0: classify, order by magnitude, align and add.
   always_comb begin
      w_sb     = i_b[31] ^ i_sub;
      w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
      w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
      w_a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
      w_b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
      w_a_zero = (i_a[30:23] == 8'h00);
      w_b_zero = (i_b[30:23] == 8'h00);

      w_spec_p0 = 1'b1;
      w_spv_p0  = '0;
      if (w_a_nan || w_b_nan)        w_spv_p0 = QNAN;
      else if (w_a_inf && w_b_inf)   w_spv_p0 = (i_a[31] != w_sb) ? QNAN : {i_a[31], 8'hFF, 23'd0};
      else if (w_a_inf)              w_spv_p0 = {i_a[31], 8'hFF, 23'd0};
      else if (w_b_inf)              w_spv_p0 = {w_sb, 8'hFF, 23'd0};
      else if (w_a_zero && w_b_zero) w_spv_p0 = {i_a[31] & w_sb, 31'd0};
      else if (w_a_zero)             w_spv_p0 = {w_sb, i_b[30:0]};
      else if (w_b_zero)             w_spv_p0 = i_a;
      else                           w_spec_p0 = 1'b0;

      w_swap = i_a[30:0] < i_b[30:0];
      w_sbig = w_swap ? w_sb : i_a[31];
      w_ssml = w_swap ? i_a[31] : w_sb;
      w_ebig = w_swap ? i_b[30:23] : i_a[30:23];
      w_esml = w_swap ? i_a[30:23] : i_b[30:23];
      w_mbig = {1'b1, (w_swap ? i_b[22:0] : i_a[22:0]), 3'b000};
      w_msml = shr_sticky({1'b1, (w_swap ? i_a[22:0] : i_b[22:0]), 3'b000}, w_ebig - w_esml);
      w_sum_p0 = (w_sbig == w_ssml) ? ({1'b0, w_mbig} + {1'b0, w_msml})
                                    : ({1'b0, w_mbig} - {1'b0, w_msml});
   end

   // Stage 1 boundary.
   always_ff @(posedge clk) begin
      if (i_en) begin
         r_spec_p1 <= w_spec_p0;
         r_spv_p1  <= w_spv_p0;
         r_sign_p1 <= w_sbig;
         r_exp_p1  <= w_ebig;
         r_sum_p1  <= w_sum_p0;
      end
   end

   // Stage 2: normalize and round.
   always_comb begin
      w_lz   = lzc27(r_sum_p1[26:0]);
      w_norm = '0;
      w_nexp = '0;
      if (r_sum_p1[27]) begin
         w_norm = {r_sum_p1[27:2], r_sum_p1[1] | r_sum_p1[0]};
         w_nexp = $signed({2'b00, r_exp_p1}) + 10'sd1;
      end else begin
         w_norm = r_sum_p1[26:0] << w_lz;
         w_nexp = $signed({2'b00, r_exp_p1}) - $signed({5'd0, w_lz});
      end
      if (r_spec_p1)              o_res = r_spv_p1;
      else if (r_sum_p1 == 28'd0) o_res = '0;
      else                        o_res = rnd_pack(r_sign_p1, w_nexp, w_norm);
   end

endmodule

// File: rtl/fpu.sv
// Binary32 FPU coprocessor with a private register file and IDLE/EXEC/DONE control.
// Compares are built only when FPU_CMP_EN is defined; otherwise they act as illegal opcodes.
module fpu
   import fpu_pkg::*;
#(
   parameter int NREG = 32,
   parameter int W    = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [4:0]   x1,
   input  logic [4:0]   x2,
   input  logic [4:0]   y,
   input  logic [5:0]   operation,
   input  logic [W-1:0] in_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] out_data,
   output logic         cond
);

   state_t r_state, w_next;

   logic [W-1:0] r_rf [NREG];
   logic [5:0]   r_op;
   logic [4:0]   r_y;
   logic [W-1:0] r_imm, r_a, r_b;
   logic         r_vld_p1;
   logic         r_valid;
   logic [W-1:0] r_out;
   logic         r_cond;

   logic         w_fin;
   logic         w_ld_p1;
   logic [W-1:0] w_add_res;
   logic [W-1:0] w_res;
   logic         w_wr, w_oupd, w_cupd, w_cval;

   logic              w_mspec_p0;
   logic [31:0]       w_mspv_p0;
   logic              w_msign_p0;
   logic signed [9:0] w_mexp_p0;
   logic [47:0]       w_mprod_p0;
   logic              r_mspec_p1;
   logic [31:0]       r_mspv_p1;
   logic              r_msign_p1;
   logic signed [9:0] r_mexp_p1;
   logic [47:0]       r_mprod_p1;
   logic [26:0]       w_mnorm;
   logic signed [9:0] w_mnexp;
   logic [31:0]       w_mul_res;

   function automatic logic [31:0] rnd_pack(input logic s, input logic signed [9:0] e,
                                            input logic [26:0] m);
      logic              up;
      logic [24:0]       mr;
      logic signed [9:0] e2;
      logic [31:0]       r;
      up = m[2] & (m[1] | m[0] | m[3]);
      mr = {1'b0, m[26:3]} + {24'd0, up};
      e2 = e;
      if (mr[24]) e2 = e + 10'sd1;
      if (e2 >= 10'sd255)     r = {s, 8'hFF, 23'd0};
      else if (e2 <= 10'sd0)  r = {s, 31'd0};
      else                    r = {s, e2[7:0], (mr[24] ? mr[23:1] : mr[22:0])};
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rstn) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (ready) w_next = S_EXEC;
         S_EXEC:  if (op_latency(r_op) == 2'd1 || r_vld_p1) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_fin   = (r_state == S_EXEC) && (w_next == S_DONE);
   assign w_ld_p1 = (r_state == S_EXEC) && !r_vld_p1;

   // Operands are captured at acceptance so the host may change inputs afterwards.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && ready) begin
         r_op  <= operation;
         r_y   <= y;
         r_imm <= in_data;
         r_a   <= r_rf[x1];
         r_b   <= r_rf[x2];
      end
   end

   fpu_addsub u_addsub (
      .clk   (clk),
      .i_en  (w_ld_p1),
      .i_sub (r_op == OPFSUB),
      .i_a   (r_a),
      .i_b   (r_b),
      .o_res (w_add_res)
   );

   // Multiply stage 0: specials, exponent sum and mantissa product.
   always_comb begin
      w_msign_p0 = r_a[31] ^ r_b[31];
      w_mexp_p0  = $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]}) - 10'sd127;
      w_mprod_p0 = {1'b1, r_a[22:0]} * {1'b1, r_b[22:0]};
      w_mspec_p0 = 1'b1;
      w_mspv_p0  = '0;
      if ((r_a[30:23] == 8'hFF && r_a[22:0] != 23'd0) || (r_b[30:23] == 8'hFF && r_b[22:0] != 23'd0))
         w_mspv_p0 = QNAN;
      else if ((r_a[30:23] == 8'hFF && r_b[30:23] == 8'h00) || (r_b[30:23] == 8'hFF && r_a[30:23] == 8'h00))
         w_mspv_p0 = QNAN;
      else if (r_a[30:23] == 8'hFF || r_b[30:23] == 8'hFF)
         w_mspv_p0 = {w_msign_p0, 8'hFF, 23'd0};
      else if (r_a[30:23] == 8'h00 || r_b[30:23] == 8'h00)
         w_mspv_p0 = {w_msign_p0, 31'd0};
      else
         w_mspec_p0 = 1'b0;
   end

   // Multiply stage 1 boundary.
   always_ff @(posedge clk) begin
      if (w_ld_p1) begin
         r_mspec_p1 <= w_mspec_p0;
         r_mspv_p1  <= w_mspv_p0;
         r_msign_p1 <= w_msign_p0;
         r_mexp_p1  <= w_mexp_p0;
         r_mprod_p1 <= w_mprod_p0;
      end
   end

   // Multiply stage 2: product is in [1,4), keep 27 bits with the hidden bit on top.
   always_comb begin
      if (r_mprod_p1[47]) begin
         w_mnorm = {r_mprod_p1[47:22], r_mprod_p1[21] | (|r_mprod_p1[20:0])};
         w_mnexp = r_mexp_p1 + 10'sd1;
      end else begin
         w_mnorm = {r_mprod_p1[46:21], |r_mprod_p1[20:0]};
         w_mnexp = r_mexp_p1;
      end
      w_mul_res = r_mspec_p1 ? r_mspv_p1 : rnd_pack(r_msign_p1, w_mnexp, w_mnorm);
   end

`ifdef FPU_CMP_EN
   logic w_nan_ab, w_zero_ab, w_eq, w_lt;

   always_comb begin
      w_nan_ab  = (r_a[30:23] == 8'hFF && r_a[22:0] != 23'd0) ||
                  (r_b[30:23] == 8'hFF && r_b[22:0] != 23'd0);
      w_zero_ab = (r_a[30:0] == 31'd0) && (r_b[30:0] == 31'd0);
      w_eq      = !w_nan_ab && ((r_a == r_b) || w_zero_ab);
      if (w_nan_ab || w_zero_ab)  w_lt = 1'b0;
      else if (r_a[31] != r_b[31]) w_lt = r_a[31];
      else if (r_a[31])            w_lt = r_a[30:0] > r_b[30:0];
      else                         w_lt = r_a[30:0] < r_b[30:0];
   end
`endif

   always_comb begin
      w_res  = '0;
      w_wr   = 1'b0;
      w_oupd = 1'b1;
      w_cupd = 1'b0;
      w_cval = 1'b0;
      case (r_op)
         OPSET:  begin w_res = r_imm;                  w_wr = 1'b1; end
         OPGET:  begin w_res = r_a;                                 end
         OPFMV:  begin w_res = r_a;                    w_wr = 1'b1; end
         OPFNEG: begin w_res = {~r_a[31], r_a[30:0]};  w_wr = 1'b1; end
         OPFABS: begin w_res = {1'b0, r_a[30:0]};      w_wr = 1'b1; end
         OPFADD,
         OPFSUB: begin w_res = w_add_res;              w_wr = 1'b1; end
         OPFMUL: begin w_res = w_mul_res;              w_wr = 1'b1; end
`ifdef FPU_CMP_EN
         OPFEQ:  begin w_oupd = 1'b0; w_cupd = 1'b1; w_cval = w_eq;         end
         OPFLT:  begin w_oupd = 1'b0; w_cupd = 1'b1; w_cval = w_lt;         end
         OPFLE:  begin w_oupd = 1'b0; w_cupd = 1'b1; w_cval = w_lt | w_eq;  end
`endif
         default: w_res = '0;
      endcase
   end

   // Results commit on entry to DONE so they are visible while valid is high.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_valid  <= 1'b0;
         r_vld_p1 <= 1'b0;
         r_out    <= '0;
         r_cond   <= 1'b0;
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else begin
         r_valid  <= w_fin;
         r_vld_p1 <= w_ld_p1 && (op_latency(r_op) == 2'd2);
         if (w_fin) begin
            if (w_wr)   r_rf[r_y] <= w_res;
            if (w_oupd) r_out     <= w_res;
            if (w_cupd) r_cond    <= w_cval;
         end
      end
   end

   assign valid    = r_valid;
   assign out_data = r_out;
   assign cond     = r_cond;

endmodule

// File: tb/tb_fpu.sv
// Directed bench for fpu: hand-computed binary32 results, latency and handshake checks.
module tb_fpu;

   localparam logic [5:0] T_SET = 6'd0,  T_GET = 6'd1,  T_FMV = 6'd2,  T_FNEG = 6'd3;
   localparam logic [5:0] T_FABS = 6'd4, T_FADD = 6'd8, T_FSUB = 6'd9, T_FMUL = 6'd10;
   localparam logic [5:0] T_FEQ = 6'd16, T_FLT = 6'd17, T_FLE = 6'd18, T_ILL = 6'd5;

`ifdef FPU_CMP_EN
   localparam bit CMP_ON = 1'b1;
`else
   localparam bit CMP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  x1, x2, y;
   logic [5:0]  operation;
   logic [31:0] in_data;
   logic        ready;
   logic        valid;
   logic [31:0] out_data;
   logic        cond;

   int n_tests = 0;
   int n_fail  = 0;

   fpu dut (
      .clk       (clk),
      .rstn      (rstn),
      .x1        (x1),
      .x2        (x2),
      .y         (y),
      .operation (operation),
      .in_data   (in_data),
      .ready     (ready),
      .valid     (valid),
      .out_data  (out_data),
      .cond      (cond)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one command, scramble inputs after acceptance, check latency/valid/out_data.
   task automatic run(input string tag, input logic [5:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic [31:0] imm,
                      input logic [31:0] exp_out, input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, "/idle_valid"}, {31'd0, valid}, 32'd0);
      operation = op; x1 = a; x2 = b; y = d; in_data = imm; ready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         operation = 6'h3F; x1 = ~a; x2 = ~b; y = ~d; in_data = ~imm;
      end while (!valid && lat < 10);
      ready = 1'b0;
      check({tag, "/valid"}, {31'd0, valid}, 32'd1);
      check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "/out"}, out_data, exp_out);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rstn = 1'b1; ready = 1'b0; operation = '0; x1 = '0; x2 = '0; y = '0; in_data = '0;
      repeat (3) @(negedge clk);
      check("rst/valid", {31'd0, valid}, 32'd0);
      check("rst/out",   out_data, 32'd0);
      check("rst/cond",  {31'd0, cond}, 32'd0);
      rstn = 1'b0;

      run("set_r0",   T_SET,  0, 0, 0, 32'h0000_0000, 32'h0000_0000, 2);
      run("set_r1",   T_SET,  0, 0, 1, 32'h3F80_0000, 32'h3F80_0000, 2);
      run("mul_0x1",  T_FMUL, 0, 1, 2, 32'h0,         32'h0000_0000, 3);
      run("mul_1x1",  T_FMUL, 1, 1, 2, 32'h0,         32'h3F80_0000, 3);
      run("get_r2",   T_GET,  2, 0, 0, 32'h0,         32'h3F80_0000, 2);

      run("set_m15",  T_SET,  0, 0, 0, 32'hBFC0_0000, 32'hBFC0_0000, 2);
      run("fmv",      T_FMV,  0, 0, 2, 32'h0,         32'hBFC0_0000, 2);
      run("set_1p7",  T_SET,  0, 0, 1, 32'h3FD9_999A, 32'h3FD9_999A, 2);
      run("mul_tie",  T_FMUL, 0, 1, 3, 32'h0,         32'hC023_3334, 3);
      run("fneg",     T_FNEG, 0, 0, 4, 32'h0,         32'h3FC0_0000, 2);
      run("fabs",     T_FABS, 0, 0, 5, 32'h0,         32'h3FC0_0000, 2);
      run("get_r3",   T_GET,  3, 0, 0, 32'h0,         32'hC023_3334, 2);

      run("set_2",    T_SET,  0, 0, 0, 32'h4000_0000, 32'h4000_0000, 2);
      run("set_1",    T_SET,  0, 0, 1, 32'h3F80_0000, 32'h3F80_0000, 2);
      run("add_2p1",  T_FADD, 0, 1, 2, 32'h0,         32'h4040_0000, 3);
      run("sub_1m1",  T_FSUB, 1, 1, 3, 32'h0,         32'h0000_0000, 3);
      run("sub_2m1",  T_FSUB, 0, 1, 4, 32'h0,         32'h3F80_0000, 3);
      run("add_self", T_FADD, 0, 0, 0, 32'h0,         32'h4080_0000, 3);
      run("get_r0",   T_GET,  0, 0, 0, 32'h0,         32'h4080_0000, 2);

      run("set_inf",  T_SET,  0, 0, 0, 32'h7F80_0000, 32'h7F80_0000, 2);
      run("inf_m_inf",T_FSUB, 0, 0, 5, 32'h0,         32'h7FC0_0000, 3);
      run("set_max",  T_SET,  0, 0, 6, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 2);
      run("set_2b",   T_SET,  0, 0, 7, 32'h4000_0000, 32'h4000_0000, 2);
      run("mul_ovf",  T_FMUL, 6, 7, 8, 32'h0,         32'h7F80_0000, 3);
      run("set_m1",   T_SET,  0, 0, 9, 32'hBF80_0000, 32'hBF80_0000, 2);
      run("x_plus_nx",T_FADD, 1, 9, 10, 32'h0,        32'h0000_0000, 3);
      run("mul_sign", T_FMUL, 9, 1, 10, 32'h0,        32'hBF80_0000, 3);
      run("mul_0inf", T_FMUL, 3, 0, 10, 32'h0,        32'h7FC0_0000, 3);

      run("set_c1",   T_SET,  0, 0, 11, 32'h3F80_0000, 32'h3F80_0000, 2);
      run("set_c2",   T_SET,  0, 0, 12, 32'h4000_0000, 32'h4000_0000, 2);
      run("flt_1_2",  T_FLT,  11, 12, 20, 32'h0, CMP_ON ? 32'h4000_0000 : 32'h0, 2);
      check("flt_1_2/cond", {31'd0, cond}, CMP_ON ? 32'd1 : 32'd0);
      run("fle_2_1",  T_FLE,  12, 11, 20, 32'h0, CMP_ON ? 32'h4000_0000 : 32'h0, 2);
      check("fle_2_1/cond", {31'd0, cond}, 32'd0);
      run("set_nz",   T_SET,  0, 0, 13, 32'h8000_0000, 32'h8000_0000, 2);
      run("set_pz",   T_SET,  0, 0, 14, 32'h0000_0000, 32'h0000_0000, 2);
      run("feq_z",    T_FEQ,  13, 14, 20, 32'h0, 32'h0, 2);
      check("feq_z/cond", {31'd0, cond}, CMP_ON ? 32'd1 : 32'd0);
      run("set_nan",  T_SET,  0, 0, 15, 32'h7FC0_0000, 32'h7FC0_0000, 2);
      run("feq_nan",  T_FEQ,  15, 15, 20, 32'h0, CMP_ON ? 32'h7FC0_0000 : 32'h0, 2);
      check("feq_nan/cond", {31'd0, cond}, 32'd0);
      run("get_r20",  T_GET,  20, 0, 0, 32'h0, 32'h0, 2);

      run("set_r16",  T_SET,  0, 0, 16, 32'h1234_5678, 32'h1234_5678, 2);
      run("illegal",  T_ILL,  0, 0, 16, 32'hFFFF_FFFF, 32'h0, 2);
      run("get_r16",  T_GET,  16, 0, 0, 32'h0, 32'h1234_5678, 2);

      // ready held high through DONE: second command accepted on the following cycle.
      @(negedge clk);
      operation = T_SET; y = 5'd17; in_data = 32'hAAAA_5555; ready = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!valid && lat < 10);
      check("b2b1/lat", 32'(lat), 32'd2);
      check("b2b1/out", out_data, 32'hAAAA_5555);
      y = 5'd18; in_data = 32'h5555_AAAA;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!valid && lat < 10);
      ready = 1'b0;
      check("b2b2/valid", {31'd0, valid}, 32'd1);
      check("b2b2/lat", 32'(lat), 32'd3);
      check("b2b2/out", out_data, 32'h5555_AAAA);
      run("get_r17",  T_GET,  17, 0, 0, 32'h0, 32'hAAAA_5555, 2);

      // Reset during EXEC aborts the command and clears state.
      @(negedge clk);
      operation = T_SET; y = 5'd19; in_data = 32'hDEAD_BEEF; ready = 1'b1;
      @(negedge clk);
      rstn = 1'b1; ready = 1'b0;
      @(negedge clk);
      check("abort/valid0", {31'd0, valid}, 32'd0);
      check("abort/out",    out_data, 32'd0);
      rstn = 1'b0;
      @(negedge clk);
      check("abort/valid1", {31'd0, valid}, 32'd0);
      run("abort/get19", T_GET, 19, 0, 0, 32'h0, 32'h0, 2);
      run("abort/get17", T_GET, 17, 0, 0, 32'h0, 32'h0, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
